result_sel_pipe: RTL and testbench

RESULT_SEL_PIPE -- requirements
Module: result_sel_pipe

---
 rtl/result_sel_pipe_pkg.sv | 20 ++
 rtl/result_sel_pipe_sel.sv | 36 +++
 rtl/result_sel_pipe.sv | 119 +++++++++++
 tb/tb_result_sel_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_sel_pipe_pkg.sv
// Shared types and constants for the result-select pipeline.
// Holds the storage-state enumeration, default datapath sizes and the
// source-index constants for the four result producers.
package result_sel_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int DEF_WL    = 32;
    localparam int DEF_NSRC  = 4;

    localparam int SRC_ARITH = 0;
    localparam int SRC_LOGIC = 1;
    localparam int SRC_SHIFT = 2;
    localparam int SRC_CMP   = 3;

endpackage

// File: rtl/result_sel_pipe_sel.sv
// Purpose: N-way result selection plus zero/negative/select-error flags.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are captured.
// Ports: sel/src_data in; data, zero, neg, selerr out.
module result_sel_core
    import result_sel_pipe_pkg::*;
#(
    parameter int WL   = DEF_WL,
    parameter int NSRC = DEF_NSRC,
    parameter int SW   = $clog2(NSRC)
) (
    input  logic [SW-1:0]      sel,
    input  logic [NSRC*WL-1:0] src_data,
    output logic [WL-1:0]      data,
    output logic               zero,
    output logic               neg,
    output logic               selerr
);

    // One extra bit so NSRC itself is representable even when it is a power of two.
    localparam logic [SW:0] NSRC_L = (SW+1)'(NSRC);

    assign selerr = ({1'b0, sel} >= NSRC_L);

    // An out-of-range index yields zero rather than reading past the bus.
    always_comb begin
        data = '0;
        if (!selerr) begin
            data = src_data[int'(sel)*WL +: WL];
        end
    end

    assign zero = (data == '0);
    assign neg  = data[WL-1];

endmodule

// File: rtl/result_sel_pipe.sv
// Purpose: selects one of NSRC results, tags it with flags and buffers it
//          in a main register plus one skid register (valid/ready both sides).
// Latency: 1 cycle from acceptance to out_valid when empty.
// Backpressure: in_ready is registered, low only when both registers hold
//               data; no combinational path from out_ready to in_ready.
// Ports: clk, rst_n; in_valid/in_ready/sel/src_data upstream;
//        out_valid/out_ready/out_data/out_zero/out_neg/out_selerr/out_count downstream.
module result_sel_pipe
    import result_sel_pipe_pkg::*;
#(
    parameter int WL   = DEF_WL,
    parameter int NSRC = DEF_NSRC,
    parameter int SW   = $clog2(NSRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SW-1:0]      sel,
    input  logic [NSRC*WL-1:0] src_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WL-1:0]      out_data,
    output logic               out_zero,
    output logic               out_neg,
    output logic               out_selerr,
    output logic [15:0]        out_count
);

    typedef struct packed {
        logic [WL-1:0] data;
        logic          zero;
        logic          neg;
        logic          selerr;
    } res_t;

    res_t          new_res;
    res_t          main_q;
    res_t          skid_q;
    state_e        state;
    logic [WL-1:0] core_data;
    logic          core_zero;
    logic          core_neg;
    logic          core_selerr;
    logic          acc;
    logic          dlv;

    result_sel_core #(
        .WL   (WL),
        .NSRC (NSRC),
        .SW   (SW)
    ) u_core (
        .sel      (sel),
        .src_data (src_data),
        .data     (core_data),
        .zero     (core_zero),
        .neg      (core_neg),
        .selerr   (core_selerr)
    );

    assign new_res = '{data: core_data, zero: core_zero, neg: core_neg, selerr: core_selerr};

    assign acc       = in_valid && in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign dlv       = out_valid && out_ready;

    assign out_data   = main_q.data;
    assign out_zero   = main_q.zero;
    assign out_neg    = main_q.neg;
    assign out_selerr = main_q.selerr;

    // in_ready is recomputed from the next state each edge, so it always
    // equals (state != ST_FULL) once out of reset and stays low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_count <= '0;
        end else begin
            in_ready <= 1'b1;
            if (dlv) begin
                out_count <= out_count + 16'd1;
            end
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        main_q <= new_res;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && dlv) begin
                        main_q <= new_res;
                    end else if (acc) begin
                        skid_q   <= new_res;
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (dlv) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (dlv) begin
                        main_q <= skid_q;
                        state  <= ST_ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_sel_pipe.sv
`timescale 1ns/1ps
module tb_result_sel_pipe;

    localparam logic [127:0] SRC = {32'h0000_0001, 32'h0000_0080, 32'h0000_F0F0, 32'hFFFF_FFFE};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [1:0]   sel;
    logic [127:0] src_data;
    logic [31:0]  out_data;
    logic         out_zero, out_neg, out_selerr;
    logic [15:0]  out_count;

    logic         in_valid3, in_ready3, out_valid3, out_ready3;
    logic [1:0]   sel3;
    logic [23:0]  src3;
    logic [7:0]   out_data3;
    logic         out_zero3, out_neg3, out_selerr3;
    logic [15:0]  out_count3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_sel_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .src_data(src_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_neg(out_neg),
        .out_selerr(out_selerr), .out_count(out_count)
    );

    result_sel_pipe #(.WL(8), .NSRC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .src_data(src3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_zero(out_zero3), .out_neg(out_neg3),
        .out_selerr(out_selerr3), .out_count(out_count3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] d;
        bit          z;
        bit          n;
        bit          e;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mcount;
    bit          rel_edge;
    bit          exp_rdy;

    function automatic exp_t expect_res(input logic [127:0] src, input int s);
        exp_t r;
        if (s >= 4) begin
            r.d = 32'h0; r.e = 1'b1;
        end else begin
            r.d = src[s*32 +: 32]; r.e = 1'b0;
        end
        r.z = (r.d == 32'h0);
        r.n = r.d[31];
        return r;
    endfunction

    // Ready may only appear on the first clock edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rel_edge <= 1'b0;
        else        rel_edge <= 1'b1;
    end

    // Compare process: checks outputs, then applies this edge's transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mcount = 16'h0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_flags", {out_zero, out_neg, out_selerr}, 0);
            chk("rst_out_count", out_count, 0);
        end else begin
            exp_rdy = rel_edge && (q.size() < 2);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, q.size() != 0);
            chk("out_count", out_count, mcount);
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0].d);
                chk("out_zero", out_zero, q[0].z);
                chk("out_neg", out_neg, q[0].n);
                chk("out_selerr", out_selerr, q[0].e);
                if (out_ready) begin
                    void'(q.pop_front());
                    mcount = mcount + 16'h1;
                end
            end
            if (in_valid && exp_rdy) q.push_back(expect_res(src_data, int'(sel)));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        in_valid = 0; sel = 0; src_data = SRC; out_ready = 0;
        in_valid3 = 0; sel3 = 0; src3 = {8'h33, 8'h80, 8'h11}; out_ready3 = 1;

        // Reset and first result
        repeat (3) tick;
        chk("reset_in_ready", in_ready, 0);
        rst_n = 1;
        chk("in_ready_before_edge", in_ready, 0);
        tick;
        chk("in_ready_after_edge", in_ready, 1);
        sel = 0; in_valid = 1; out_ready = 1;
        tick;
        in_valid = 0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 64'hFFFF_FFFE);
        chk("t1_out_neg", out_neg, 1);
        chk("t1_count_pre", out_count, 0);
        tick;
        chk("t1_count_post", out_count, 1);
        chk("t1_empty", out_valid, 0);

        // Backpressure: two results fill the block, a third is held off
        out_ready = 0; in_valid = 1; sel = 1;
        tick;
        sel = 2;
        tick;
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_head", out_data, 64'hF0F0);
        sel = 3;
        tick; tick;
        chk("t2_head_stable", out_data, 64'hF0F0);
        out_ready = 1;
        tick;
        chk("t2_second", out_data, 64'h80);
        chk("t2_ready_back", in_ready, 1);
        tick;
        in_valid = 0;
        chk("t2_held_third", out_data, 64'h1);
        tick;
        chk("t2_count", out_count, 4);
        chk("t2_drained", out_valid, 0);

        // Streaming: accept and deliver every cycle
        for (int i = 0; i < 8; i++) begin
            sel = 2'(i);
            src_data = {32'h0, 32'(i) << 4, ~32'(i), 32'(-i)};
            in_valid = 1; out_ready = 1;
            tick;
            chk("t3_in_ready", in_ready, 1);
            chk("t3_out_valid", out_valid, 1);
            if (i == 0) chk("t3_zero_first", out_zero, 1);
        end
        in_valid = 0;
        tick;
        chk("t3_count", out_count, 12);
        src_data = SRC;

        // Out-of-range select on a 3-source instance
        sel3 = 3; in_valid3 = 1;
        tick;
        chk("t4_selerr_data", out_data3, 0);
        chk("t4_selerr_flag", out_selerr3, 1);
        chk("t4_selerr_zero", out_zero3, 1);
        chk("t4_selerr_neg", out_neg3, 0);
        sel3 = 1;
        tick;
        chk("t4_neg_data", out_data3, 64'h80);
        chk("t4_neg_flag", {out_neg3, out_selerr3, out_zero3}, 3'b100);
        sel3 = 2;
        tick;
        in_valid3 = 0;
        chk("t4_data2", out_data3, 64'h33);
        chk("t4_flags2", {out_neg3, out_selerr3, out_zero3}, 3'b000);
        tick;
        chk("t4_count", out_count3, 3);

        // Reset while FULL
        out_ready = 0; in_valid = 1; sel = 1;
        tick; tick;
        in_valid = 0;
        chk("t5_full", in_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_count", out_count, 0);
        chk("t5_async_data", out_data, 0);
        tick; tick;
        rst_n = 1;
        out_ready = 1;
        tick; tick;
        chk("t5_no_stale", out_valid, 0);
        chk("t5_count", out_count, 0);

        // Counter wrap over 65536 deliveries
        n = 0; cyc = 0;
        in_valid = 1; out_ready = 1;
        while (n < 65536 && cyc < 70000) begin
            sel = 2'(cyc);
            @(negedge clk);
            if (in_ready) n++;
            tick;
            cyc++;
        end
        in_valid = 0;
        chk("t6_accepts", n, 65536);
        for (int k = 0; k < 5 && out_valid; k++) tick;
        chk("t6_drained", out_valid, 0);
        chk("t6_wrap_count", out_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
